sub_div_seq: RTL

Sequential 4-bit unsigned divider that sequences the shared 4-bit subtractor datapath (`result = a - b` mod 16, `sign = 1` when `a < b`) by repeated subtraction. It accepts one operand pair per start pulse, iterates one subtraction per clock, and reports quotient, remainder and a divide-by-zero flag with a one-cycle done pulse. It sits between a requesting controller (or testbench) and the subtractor, which it instantiates internally.

---
 rtl/sub_div_seq.sv | 99 +++++++++
 1 files changed

// File: rtl/sub_div_seq.sv
// Sequential 4-bit unsigned divider built on a shared 4-bit subtractor (repeated subtraction).
// Optional build macro SUB_DIV_BYPASS_EN: divisor == 1 finishes directly from IDLE in one cycle.

module sub_div_sub4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] result,
  output logic       sign
);
  assign result = a - b;
  assign sign   = (a < b);
endmodule

module sub_div_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SUB  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic [3:0] div_q;
  logic [3:0] rem;
  logic [3:0] q;
  logic       dbz;
  logic [3:0] sub_result;
  logic       sub_sign;

  sub_div_sub4 u_sub (
    .a      (rem),
    .b      (div_q),
    .result (sub_result),
    .sign   (sub_sign)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      div_q <= 4'd0;
      rem   <= 4'd0;
      q     <= 4'd0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            div_q <= divisor;
            rem   <= dividend;
            q     <= 4'd0;
            dbz   <= 1'b0;
            if (divisor == 4'd0) begin
              state <= DONE;
              dbz   <= 1'b1;
              q     <= 4'hF;
            end
`ifdef SUB_DIV_BYPASS_EN
            else if (divisor == 4'd1) begin
              state <= DONE;
              q     <= dividend;
              rem   <= 4'd0;
            end
`endif
            else begin
              state <= SUB;
            end
          end
        end
        SUB: begin
          // A borrow means rem < divisor: rem/q already hold the final answer.
          if (!sub_sign) begin
            rem <= sub_result;
            q   <= q + 4'd1;
          end else begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign quotient    = q;
  assign remainder   = rem;
  assign div_by_zero = dbz;

endmodule
